// File: rtl/sap_control_sequencer_if.sv
// Control bus between the SAP microcode sequencer and the datapath.
// master: the datapath side (supplies run/opcode/flags, consumes controls).
// slave:  the sequencer (consumes run/opcode/flags, drives controls).
interface sap_control_sequencer_if #(
  parameter int OPW  = 4,
  parameter int SELW = 4
);
  logic            run;
  logic [OPW-1:0]  opcode;
  logic            CF;
  logic            ZF;
  logic [SELW-1:0] src_sel;
  logic [SELW-1:0] dst_sel;
  logic            OE;
  logic            load;
  logic            WE;
  logic            en;
  logic            SUB;
  logic            HLT;
  logic [2:0]      step;

  modport master (
    output run, opcode, CF, ZF,
    input  src_sel, dst_sel, OE, load, WE, en, SUB, HLT, step
  );

  modport slave (
    input  run, opcode, CF, ZF,
    output src_sel, dst_sel, OE, load, WE, en, SUB, HLT, step
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// Microcoded control sequencer for the 8-bit bus computer.
// Fixed fetch in T0-T1, per-opcode execute in T2-T4, early return to T0
// after the last microstep. The control word is a pure combinational decode
// of (phase, step, opcode, flags), so an async reset kills it instantly.
module sap_control_sequencer #(
  parameter int OPW       = 4,
  parameter int SELW      = 4,
  parameter int NUM_STEPS = 5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  sap_control_sequencer_if.slave bus
);
  // bus module select codes
  localparam logic [SELW-1:0] SEL_A    = SELW'(0);
  localparam logic [SELW-1:0] SEL_B    = SELW'(1);
  localparam logic [SELW-1:0] SEL_IR   = SELW'(2);
  localparam logic [SELW-1:0] SEL_MAR  = SELW'(3);
  localparam logic [SELW-1:0] SEL_RAM  = SELW'(4);
  localparam logic [SELW-1:0] SEL_ALU  = SELW'(5);
  localparam logic [SELW-1:0] SEL_OUT  = SELW'(6);
  localparam logic [SELW-1:0] SEL_PC   = SELW'(9);
  localparam logic [SELW-1:0] SEL_NONE = SELW'(15);

  // opcodes (anything not listed decodes as NOP)
  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4);
  localparam logic [OPW-1:0] OP_LDI = OPW'(5);
  localparam logic [OPW-1:0] OP_JMP = OPW'(6);
  localparam logic [OPW-1:0] OP_JC  = OPW'(7);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
  localparam logic [OPW-1:0] OP_OUT = OPW'(14);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  // sequencer phase: waiting at the instruction boundary, running, halted
  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_RUN  = 2'd1;
  localparam logic [1:0] PH_HALT = 2'd2;

  localparam logic [2:0] STEP_MAX = 3'(NUM_STEPS - 1);

  logic [1:0]      phase;
  logic [2:0]      step_q;
  logic [2:0]      last_step;
  logic            xv;
  logic [SELW-1:0] xs, xd;

  // last microstep of the current opcode (only consulted from T2 on)
  always_comb begin
    unique case (bus.opcode)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = STEP_MAX;
      default:        last_step = 3'd2;
    endcase
  end

  // step counter and phase; run is only looked at on the way into T0
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      phase  <= PH_IDLE;
      step_q <= 3'd0;
    end else begin
      unique case (phase)
        PH_IDLE: begin
          step_q <= 3'd0;
          if (bus.run) phase <= PH_RUN;
        end
        PH_RUN: begin
          if (step_q == 3'd2 && bus.opcode == OP_HLT) begin
            phase <= PH_HALT;          // step freezes at 2
          end else if (step_q >= last_step || step_q >= STEP_MAX) begin
            step_q <= 3'd0;
            if (!bus.run) phase <= PH_IDLE;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        PH_HALT: ;                     // only reset leaves
        default: begin
          phase  <= PH_IDLE;
          step_q <= 3'd0;
        end
      endcase
    end
  end

  // control word decode: pick one bus transfer (xs->xd) plus side controls
  always_comb begin
    xv          = 1'b0;
    xs          = SEL_NONE;
    xd          = SEL_NONE;
    bus.en      = 1'b0;
    bus.SUB     = 1'b0;
    bus.HLT     = 1'b0;
    if (phase == PH_HALT) begin
      bus.HLT = 1'b1;
    end else if (phase == PH_RUN) begin
      unique case (step_q)
        3'd0: begin xv = 1'b1; xs = SEL_PC;  xd = SEL_MAR; end
        3'd1: begin xv = 1'b1; xs = SEL_RAM; xd = SEL_IR; bus.en = 1'b1; end
        3'd2: begin
          unique case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin xv = 1'b1; xs = SEL_IR; xd = SEL_MAR; end
            OP_LDI: begin xv = 1'b1;    xs = SEL_IR; xd = SEL_A;   end
            OP_JMP: begin xv = 1'b1;    xs = SEL_IR; xd = SEL_PC;  end
            OP_JC:  begin xv = bus.CF;  xs = bus.CF ? SEL_IR : SEL_NONE; xd = bus.CF ? SEL_PC : SEL_NONE; end
            OP_JZ:  begin xv = bus.ZF;  xs = bus.ZF ? SEL_IR : SEL_NONE; xd = bus.ZF ? SEL_PC : SEL_NONE; end
            OP_OUT: begin xv = 1'b1;    xs = SEL_A;  xd = SEL_OUT; end
            OP_HLT: bus.HLT = 1'b1;
            default: ;
          endcase
        end
        3'd3: begin
          unique case (bus.opcode)
            OP_LDA:         begin xv = 1'b1; xs = SEL_RAM; xd = SEL_A;   end
            OP_ADD, OP_SUB: begin xv = 1'b1; xs = SEL_RAM; xd = SEL_B;   end
            OP_STA:         begin xv = 1'b1; xs = SEL_A;   xd = SEL_RAM; end
            default: ;
          endcase
        end
        3'd4: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            xv      = 1'b1;
            xs      = SEL_ALU;
            xd      = SEL_A;
            bus.SUB = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  // a transfer into RAM is a write, into anything else a register load
  assign bus.src_sel = xs;
  assign bus.dst_sel = xd;
  assign bus.OE      = xv;
  assign bus.WE      = xv && (xd == SEL_RAM);
  assign bus.load    = xv && (xd != SEL_RAM);
  assign bus.step    = step_q;
endmodule

// File: tb/tb_sap_control_sequencer.sv
// Randomized bench for the SAP control sequencer. Each instruction is
// expanded into its list of microstep control words from the instruction
// table; those words are queued as they are driven and a negedge monitor
// pops and compares them against the live control word.
module tb_sap_control_sequencer;
  localparam logic [3:0] S_A = 4'd0, S_B = 4'd1, S_IR = 4'd2, S_MAR = 4'd3,
                         S_RAM = 4'd4, S_ALU = 4'd5, S_OUT = 4'd6,
                         S_PC = 4'd9, S_NONE = 4'd15;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] dst;
    logic       oe, load, we, en, sub, hlt;
    logic [2:0] step;
  } cw_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  sap_control_sequencer_if #(.OPW(4), .SELW(4)) bus ();

  sap_control_sequencer #(.OPW(4), .SELW(4), .NUM_STEPS(5)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  cw_t q[$];
  cw_t seq[5];
  int  checks = 0;
  int  fails  = 0;

  function automatic cw_t quiet(input int st);
    cw_t w;
    w      = '0;
    w.src  = S_NONE;
    w.dst  = S_NONE;
    w.step = 3'(st);
    return w;
  endfunction

  // one bus move: source drives, destination latches (RAM is written)
  function automatic cw_t xfer(input int st, input logic [3:0] s, input logic [3:0] d);
    cw_t w;
    w     = quiet(st);
    w.src = s;
    w.dst = d;
    w.oe  = 1'b1;
    if (d == S_RAM) w.we = 1'b1;
    else            w.load = 1'b1;
    return w;
  endfunction

  // instruction table -> microstep words in seq[], returns length
  function automatic int build(input logic [3:0] op, input logic cf, input logic zf);
    int n;
    seq[0] = xfer(0, S_PC, S_MAR);
    seq[1] = xfer(1, S_RAM, S_IR);
    seq[1].en = 1'b1;
    n = 3;
    case (op)
      4'd1: begin seq[2] = xfer(2, S_IR, S_MAR); seq[3] = xfer(3, S_RAM, S_A); n = 4; end
      4'd2, 4'd3: begin
        seq[2] = xfer(2, S_IR, S_MAR);
        seq[3] = xfer(3, S_RAM, S_B);
        seq[4] = xfer(4, S_ALU, S_A);
        seq[4].sub = (op == 4'd3);
        n = 5;
      end
      4'd4: begin seq[2] = xfer(2, S_IR, S_MAR); seq[3] = xfer(3, S_A, S_RAM); n = 4; end
      4'd5:  seq[2] = xfer(2, S_IR, S_A);
      4'd6:  seq[2] = xfer(2, S_IR, S_PC);
      4'd7:  seq[2] = cf ? xfer(2, S_IR, S_PC) : quiet(2);
      4'd8:  seq[2] = zf ? xfer(2, S_IR, S_PC) : quiet(2);
      4'd14: seq[2] = xfer(2, S_A, S_OUT);
      4'd15: begin seq[2] = quiet(2); seq[2].hlt = 1'b1; end
      default: seq[2] = quiet(2);
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // scoreboard monitor: one queued word per sampled cycle
  always @(negedge CLK) begin : monitor
    cw_t e, a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a.src = bus.src_sel; a.dst = bus.dst_sel;
      a.oe = bus.OE; a.load = bus.load; a.we = bus.WE;
      a.en = bus.en; a.sub = bus.SUB; a.hlt = bus.HLT; a.step = bus.step;
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL cw t=%0t: got src=%h dst=%h oe%b ld%b we%b en%b sub%b hlt%b step=%0d required src=%h dst=%h oe%b ld%b we%b en%b sub%b hlt%b step=%0d",
                 $time, a.src, a.dst, a.oe, a.load, a.we, a.en, a.sub, a.hlt, a.step,
                 e.src, e.dst, e.oe, e.load, e.we, e.en, e.sub, e.hlt, e.step);
      end
    end
  end

  // one cycle at the instruction boundary with run = r
  task automatic idle(input logic r);
    @(posedge CLK); #1;
    bus.run    = r;
    bus.opcode = 4'($urandom);
    q.push_back(quiet(0));
  endtask

  // two cycles in reset, then one released boundary cycle with run=1
  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      RESET   = 1'b0;
      bus.run = 1'b1;
      q.push_back(quiet(0));
    end
    @(posedge CLK); #1;
    RESET   = 1'b1;
    bus.run = 1'b1;
    q.push_back(quiet(0));
  endtask

  // run one instruction; run is random except at the last step.
  // abort >= 0 pulls reset low mid-cycle during that step.
  task automatic run_instr(input logic [3:0] op, input logic cf, input logic zf,
                           input logic run_last, input int abort);
    int n;
    n = build(op, cf, zf);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      bus.opcode = (i < 2) ? 4'($urandom) : op;
      bus.CF     = (i == 2) ? cf : 1'($urandom);
      bus.ZF     = (i == 2) ? zf : 1'($urandom);
      bus.run    = (i == n - 1) ? run_last : 1'($urandom);
      q.push_back(seq[i]);
      if (i == abort) begin
        @(negedge CLK); #2;
        RESET = 1'b0;
        #1;
        chk("async_reset_WE", int'(bus.WE), 0);
        chk("async_reset_OE", int'(bus.OE), 0);
        chk("async_reset_step", int'(bus.step), 0);
        chk("async_reset_dst", int'(bus.dst_sel), int'(S_NONE));
        return;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] op;
    logic       r;
    RESET = 1'b0;
    bus.run = 1'b0; bus.opcode = 4'd0; bus.CF = 1'b0; bus.ZF = 1'b0;
    do_reset();
    run_instr(4'd1, 1'b0, 1'b0, 1'b1, -1);   // LDA
    run_instr(4'd3, 1'b0, 1'b0, 1'b1, -1);   // SUB
    run_instr(4'd8, 1'b0, 1'b1, 1'b1, -1);   // JZ taken
    run_instr(4'd8, 1'b1, 1'b0, 1'b1, -1);   // JZ not taken
    run_instr(4'd7, 1'b1, 1'b0, 1'b1, -1);   // JC taken
    run_instr(4'd2, 1'b0, 1'b0, 1'b0, -1);   // ADD, run dropped
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    for (int k = 0; k < 200; k++) begin
      op = 4'($urandom_range(0, 14));
      r  = 1'($urandom);
      run_instr(op, 1'($urandom), 1'($urandom), r, -1);
      if (!r) begin
        repeat ($urandom_range(0, 3)) idle(1'b0);
        idle(1'b1);
      end
    end
    run_instr(4'd4, 1'b0, 1'b0, 1'b1, 3);    // STA, reset in T3
    do_reset();
    run_instr(4'd15, 1'b0, 1'b0, 1'($urandom), -1);   // HLT
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      bus.run    = 1'($urandom);
      bus.opcode = 4'($urandom);
      bus.CF     = 1'($urandom);
      q.push_back(seq[2]);
    end
    do_reset();
    run_instr(4'd5, 1'b0, 1'b0, 1'b1, -1);   // LDI after recovery
    repeat (2) @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
